// File: rtl/md5_padder.sv
// Byte-serial MD5 padder: packs bytes into 512-bit blocks, appends 0x80/zero/length, feeds core as 4x128-bit words.
// Latency: last byte edge t -> first load after edge t+2; backpressure: byte_ready_o low outside FILL, WAIT holds until core ready & armed.
module md5_padder #(
    parameter int CNT_W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         byte_valid_i,
    input  logic [7:0]   byte_i,
    input  logic         last_i,
    output logic         byte_ready_o,
    input  logic         core_ready_i,
    output logic         load_o,
    output logic         newtext_o,
    output logic [127:0] data_o,
    output logic         busy_o
);

    typedef enum logic [2:0] {S_FILL, S_PAD, S_WAIT, S_SEND, S_PAD2} state_t;

    state_t                 state_q, state_d;
    logic [3:0][127:0]      blk_q, blk_d;
    logic [5:0]             pos_q, pos_d;
    logic [5:0]             last_p_q, last_p_d;
    logic [CNT_W-1:0]       count_q, count_d;
    logic [1:0]             word_q, word_d;
    logic                   armed_q, armed_d;
    logic                   first_q, first_d;
    logic                   final_q, final_d;
    logic                   pad2_q, pad2_d;
    logic                   extra80_q, extra80_d;
    logic                   busy_q, busy_d;
    logic                   byte_ready_q, byte_ready_d;
    logic                   load_q, load_d;
    logic                   newtext_q, newtext_d;
    logic [127:0]           data_q, data_d;

    logic [63:0]            bit_len;
    logic [6:0]             last_p1;

    // Bit offset of block byte p inside its 128-bit word: lane 0 is the top 32 bits, bytes little-endian in a lane.
    function automatic logic [6:0] byte_off(input logic [5:0] p);
        return {~p[3:2], p[1:0], 3'b000};
    endfunction

    assign bit_len = 64'({count_q, 3'b000});
    assign last_p1 = {1'b0, last_p_q} + 7'd1;

    always_comb begin
        state_d   = state_q;
        blk_d     = blk_q;
        pos_d     = pos_q;
        last_p_d  = last_p_q;
        count_d   = count_q;
        word_d    = word_q;
        armed_d   = armed_q;
        first_d   = first_q;
        final_d   = final_q;
        pad2_d    = pad2_q;
        extra80_d = extra80_q;
        busy_d    = busy_q;
        load_d    = 1'b0;
        newtext_d = 1'b0;
        data_d    = '0;

        // A ready cycle after the last word is needed before the next launch.
        if (state_q == S_SEND && word_q == 2'd3) begin
            armed_d = 1'b0;
        end else if (!core_ready_i) begin
            armed_d = 1'b1;
        end

        case (state_q)
            S_FILL: begin
                if (byte_valid_i && byte_ready_q) begin
                    blk_d[pos_q[5:4]][byte_off(pos_q) +: 8] = byte_i;
                    count_d = count_q + CNT_W'(1);
                    busy_d  = 1'b1;
                    pos_d   = pos_q + 6'd1;
                    if (last_i) begin
                        last_p_d = pos_q;
                        pos_d    = 6'd0;
                        state_d  = S_PAD;
                    end else if (pos_q == 6'd63) begin
                        state_d = S_WAIT;
                    end
                end
            end
            S_PAD: begin
                for (int q = 0; q < 64; q++) begin
                    if (7'(q) == last_p1) begin
                        blk_d[q[5:4]][byte_off(q[5:0]) +: 8] = 8'h80;
                    end else if (7'(q) > last_p1) begin
                        blk_d[q[5:4]][byte_off(q[5:0]) +: 8] = 8'h00;
                    end
                end
                if (last_p1 <= 7'd55) begin
                    blk_d[3][63:32] = bit_len[31:0];
                    blk_d[3][31:0]  = bit_len[63:32];
                    final_d = 1'b1;
                    pad2_d  = 1'b0;
                end else begin
                    final_d = 1'b0;
                    pad2_d  = 1'b1;
                end
                extra80_d = (last_p_q == 6'd63);
                state_d   = S_WAIT;
            end
            S_WAIT: begin
                if (core_ready_i && armed_q) begin
                    load_d    = 1'b1;
                    data_d    = blk_q[0];
                    newtext_d = first_q;
                    first_d   = 1'b0;
                    word_d    = 2'd1;
                    state_d   = S_SEND;
                end
            end
            S_SEND: begin
                load_d = 1'b1;
                data_d = blk_q[word_q];
                word_d = word_q + 2'd1;
                if (word_q == 2'd3) begin
                    if (pad2_q) begin
                        pad2_d  = 1'b0;
                        state_d = S_PAD2;
                    end else begin
                        state_d = S_FILL;
                        if (final_q) begin
                            count_d = '0;
                            first_d = 1'b1;
                            final_d = 1'b0;
                            busy_d  = 1'b0;
                        end
                    end
                end
            end
            S_PAD2: begin
                blk_d = '0;
                if (extra80_q) begin
                    blk_d[0][103:96] = 8'h80;
                end
                blk_d[3][63:32] = bit_len[31:0];
                blk_d[3][31:0]  = bit_len[63:32];
                final_d = 1'b1;
                state_d = S_WAIT;
            end
            default: state_d = S_FILL;
        endcase

        byte_ready_d = (state_d == S_FILL);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_FILL;
            blk_q        <= '0;
            pos_q        <= '0;
            last_p_q     <= '0;
            count_q      <= '0;
            word_q       <= '0;
            armed_q      <= 1'b1;
            first_q      <= 1'b1;
            final_q      <= 1'b0;
            pad2_q       <= 1'b0;
            extra80_q    <= 1'b0;
            busy_q       <= 1'b0;
            byte_ready_q <= 1'b0;
            load_q       <= 1'b0;
            newtext_q    <= 1'b0;
            data_q       <= '0;
        end else begin
            state_q      <= state_d;
            blk_q        <= blk_d;
            pos_q        <= pos_d;
            last_p_q     <= last_p_d;
            count_q      <= count_d;
            word_q       <= word_d;
            armed_q      <= armed_d;
            first_q      <= first_d;
            final_q      <= final_d;
            pad2_q       <= pad2_d;
            extra80_q    <= extra80_d;
            busy_q       <= busy_d;
            byte_ready_q <= byte_ready_d;
            load_q       <= load_d;
            newtext_q    <= newtext_d;
            data_q       <= data_d;
        end
    end

    assign byte_ready_o = byte_ready_q;
    assign load_o       = load_q;
    assign newtext_o    = newtext_q;
    assign data_o       = data_q;
    assign busy_o       = busy_q;

endmodule

// File: tb/tb_md5_padder.sv
// Scoreboard bench for md5_padder: directed messages, expected core words queued at issue, checked by a load monitor.
module tb_md5_padder;

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic         byte_valid_i = 1'b0;
    logic [7:0]   byte_i = 8'h00;
    logic         last_i = 1'b0;
    logic         core_ready_i = 1'b0;
    logic         byte_ready_o;
    logic         load_o;
    logic         newtext_o;
    logic [127:0] data_o;
    logic         busy_o;

    md5_padder #(.CNT_W(32)) dut (
        .clk          (clk),
        .reset        (reset),
        .byte_valid_i (byte_valid_i),
        .byte_i       (byte_i),
        .last_i       (last_i),
        .byte_ready_o (byte_ready_o),
        .core_ready_i (core_ready_i),
        .load_o       (load_o),
        .newtext_o    (newtext_o),
        .data_o       (data_o),
        .busy_o       (busy_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           nt;
        logic [127:0] d;
    } exp_t;

    localparam logic [127:0] A_W0   = 128'h00008061_00000000_00000000_00000000;
    localparam logic [127:0] A_W3   = 128'h00000000_00000000_00000008_00000000;
    localparam logic [127:0] ABC_W0 = 128'h80636261_00000000_00000000_00000000;
    localparam logic [127:0] ABC_W3 = 128'h00000000_00000000_00000018_00000000;
    localparam logic [127:0] Z56_B1 = 128'h00000000_00000000_00000080_00000000;
    localparam logic [127:0] Z56_B2 = 128'h00000000_00000000_000001C0_00000000;
    localparam logic [127:0] Z64_W0 = 128'h00000080_00000000_00000000_00000000;
    localparam logic [127:0] Z64_W3 = 128'h00000000_00000000_00000200_00000000;

    exp_t exp_q[$];
    exp_t mon_e;
    int   tests = 0;
    int   fails = 0;
    bit   core_en = 1'b1;
    bit   core_drop = 1'b1;
    int   busy_cnt = 0;
    int   run_len = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic push_block(input bit nt, input logic [127:0] w0, input logic [127:0] w1,
                              input logic [127:0] w2, input logic [127:0] w3);
        exp_t e;
        e.nt = nt;   e.d = w0; exp_q.push_back(e);
        e.nt = 1'b0; e.d = w1; exp_q.push_back(e);
        e.d = w2; exp_q.push_back(e);
        e.d = w3; exp_q.push_back(e);
    endtask

    task automatic send_byte(input logic [7:0] b, input bit last);
        int guard;
        guard = 0;
        @(negedge clk);
        byte_valid_i = 1'b1;
        byte_i       = b;
        last_i       = last;
        while (!byte_ready_o && guard < 2000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 2000) begin
            tests++;
            fails++;
            $display("FAIL send_timeout: byte_ready_o stayed %b, required 1", byte_ready_o);
        end
        @(posedge clk);
        #1;
        byte_valid_i = 1'b0;
        last_i       = 1'b0;
    endtask

    task automatic send_n(input int n, input logic [7:0] b);
        for (int i = 0; i < n; i++) send_byte(b, i == n - 1);
    endtask

    task automatic wait_drain(input string name);
        int guard;
        guard = 0;
        while (exp_q.size() != 0 && guard < 400) begin
            @(posedge clk);
            guard++;
        end
        check(name, 128'(exp_q.size()), 128'd0);
        exp_q.delete();
        repeat (12) @(posedge clk);
    endtask

    // Core stand-in: drops ready while "hashing" after each load unless core_drop is cleared.
    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (load_o && core_drop) busy_cnt = 6;
            else if (busy_cnt > 0) busy_cnt--;
            core_ready_i = core_en && (busy_cnt == 0);
        end
    end

    always @(negedge clk) begin
        if (reset) begin
            run_len = 0;
        end else if (load_o) begin
            run_len++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_load: data %h newtext %b, no load required", data_o, newtext_o);
            end else begin
                mon_e = exp_q.pop_front();
                check("load_data", data_o, mon_e.d);
                check("load_newtext", 128'(newtext_o), 128'(mon_e.nt));
            end
        end else begin
            if (run_len != 0) begin
                check("load_run_len", 128'(run_len), 128'd4);
                run_len = 0;
            end
            check("idle_data_zero", data_o, 128'd0);
            check("idle_newtext_zero", 128'(newtext_o), 128'd0);
        end
    end

    initial begin
        int lat;
        repeat (3) @(negedge clk);
        check("rst_byte_ready", 128'(byte_ready_o), 128'd0);
        check("rst_load", 128'(load_o), 128'd0);
        check("rst_busy", 128'(busy_o), 128'd0);
        check("rst_data", data_o, 128'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("ready_after_release", 128'(byte_ready_o), 128'd1);

        // "a" with latency measurement
        push_block(1'b1, A_W0, 128'd0, 128'd0, A_W3);
        send_byte(8'h61, 1'b1);
        check("busy_during_msg", 128'(busy_o), 128'd1);
        lat = 0;
        while (!load_o && lat < 20) begin
            @(posedge clk);
            #1;
            lat++;
        end
        check("first_load_latency", 128'(lat), 128'd2);
        wait_drain("drain_a");
        check("busy_after_a", 128'(busy_o), 128'd0);

        // "abc"
        push_block(1'b1, ABC_W0, 128'd0, 128'd0, ABC_W3);
        send_byte(8'h61, 1'b0);
        send_byte(8'h62, 1'b0);
        send_byte(8'h63, 1'b1);
        wait_drain("drain_abc");

        // 56 zero bytes: length spills into a second block
        push_block(1'b1, 128'd0, 128'd0, 128'd0, Z56_B1);
        push_block(1'b0, 128'd0, 128'd0, 128'd0, Z56_B2);
        send_n(56, 8'h00);
        wait_drain("drain_z56");

        // 64 zero bytes: 0x80 opens the extra block
        push_block(1'b1, 128'd0, 128'd0, 128'd0, 128'd0);
        push_block(1'b0, Z64_W0, 128'd0, 128'd0, Z64_W3);
        send_n(64, 8'h00);
        wait_drain("drain_z64");

        // Core not ready: block is held, no bytes accepted
        core_en = 1'b0;
        repeat (2) @(posedge clk);
        push_block(1'b1, A_W0, 128'd0, 128'd0, A_W3);
        send_byte(8'h61, 1'b1);
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("stall_load_low", 128'(load_o), 128'd0);
            check("stall_ready_low", 128'(byte_ready_o), 128'd0);
        end
        core_drop = 1'b0;
        core_en   = 1'b1;
        wait_drain("drain_stall");
        repeat (20) @(posedge clk);
        check("ready_after_stall", 128'(byte_ready_o), 128'd1);

        // Ready held high: the extra block must not launch on a stale ready
        core_en = 1'b0;
        repeat (3) @(posedge clk);
        core_en = 1'b1;
        push_block(1'b1, 128'd0, 128'd0, 128'd0, 128'd0);
        send_n(64, 8'h00);
        wait_drain("drain_held_blk1");
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            check("held_no_relaunch", 128'(load_o), 128'd0);
        end
        check("held_busy", 128'(busy_o), 128'd1);
        push_block(1'b0, Z64_W0, 128'd0, 128'd0, Z64_W3);
        core_en = 1'b0;
        repeat (2) @(posedge clk);
        core_en   = 1'b1;
        core_drop = 1'b1;
        wait_drain("drain_held_blk2");

        // Reset mid-message
        for (int i = 0; i < 10; i++) send_byte(8'(i + 1), 1'b0);
        @(negedge clk);
        check("pre_reset_busy", 128'(busy_o), 128'd1);
        reset = 1'b1;
        #1;
        check("mid_rst_load", 128'(load_o), 128'd0);
        check("mid_rst_newtext", 128'(newtext_o), 128'd0);
        check("mid_rst_data", data_o, 128'd0);
        check("mid_rst_busy", 128'(busy_o), 128'd0);
        check("mid_rst_ready", 128'(byte_ready_o), 128'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        push_block(1'b1, A_W0, 128'd0, 128'd0, A_W3);
        send_byte(8'h61, 1'b1);
        wait_drain("drain_after_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, %0d tests run, %0d failed", tests, fails);
        $fatal(1);
    end

endmodule

// File: doc/md5_padder.md
# md5_padder

Upstream feeder for the `md5` core. Accepts a message one byte per cycle, buffers it into 512-bit blocks, and appends MD5 padding: `0x80`, zero fill, and the 64-bit little-endian bit length. It presents each block to the core as four 128-bit words using the core's `load_i`/`newtext_i`/`data_i` protocol, gated by the core's `ready_o`.

## Interface
- `CNT_W`, default 32: byte-counter width.
  - Bit length is `{count, 3'b000}`, zero-extended to 64 bits.
  - Count wraps modulo 2^CNT_W.

Ports:
- `clk` in 1: single clock, rising edge.
- `reset` in 1: asynchronous, active-high.
- `byte_valid_i` in 1: `byte_i` is valid this cycle.
- `byte_i` in 8: message byte.
- `last_i` in 1: qualifies `byte_valid_i`; marks the final byte of the message.
- `byte_ready_o` out 1: padder accepts a byte this cycle.
- `core_ready_i` in 1: core `ready_o`; core is idle and can take a block.
- `load_o` out 1: to core `load_i`; one word per high cycle.
- `newtext_o` out 1: to core `newtext_i`; first word of a new message.
- `data_o` out 128: to core `data_i`.
- `busy_o` out 1: a message is in progress.

## Operation
- States:
  - FILL: accepting bytes.
  - PAD: build the final block.
  - WAIT: block ready, waiting for the core.
  - SEND: 2-bit word index, 0..3.
  - PAD2: build the extra padding block.
- Byte accepted on a rising edge when `byte_valid_i & byte_ready_o`. `byte_ready_o` = 1 only in FILL. Bytes offered while it is low are ignored.
- Byte packing, with byte k of the block at position p = k mod 64:
  - word w = p/16;
  - 32-bit lane L = (p/4) mod 4, where lane 0 = `[127:96]` and lane 3 = `[31:0]`;
  - within the lane, bits `[8b+7:8b]`, b = p mod 4. This is MD5 little-endian word order.
- 64th byte accepted without `last_i`: go to WAIT. Buffer position resets to 0 and count continues.
- `last_i` byte accepted at position p: go to PAD.
  - `0x80` is placed at p+1. If p = 63, it is instead placed at byte 0 of the extra block.
  - Bytes after the `0x80` are zeroed.
- Length goes in word 3: bits `[31:0]` of the bit length in lane 2, bits `[63:32]` in lane 3.
  - If the `0x80` lands at position ≤ 55, the length goes in this block, which is final.
  - Otherwise this block carries no length and PAD2 follows. PAD2 builds a zero block (holding the `0x80` at byte 0 if p was 63) plus the length.
- Launch handshake:
  - `armed` flag, reset value 1.
  - Leave WAIT for SEND only when `core_ready_i & armed`.
  - `armed` clears on word 3 and sets on any cycle with `core_ready_i` = 0. This prevents a stale ready from launching a second block.
- `newtext_o` = 1 with word 0 of the first block of each message only.
- After SEND word 3:
  - PAD2 if the extra block is pending;
  - else FILL. Count clears if the message has ended.
- Empty messages are unsupported: at least one byte must be sent with `last_i`.
- `busy_o` = 1 from the first accepted byte until word 3 of the message's final block.

## Timing
- Reset values, while `reset` is high: all outputs 0, state FILL, count 0, buffer 0, `armed` 1.
  - `byte_ready_o` rises in the first cycle after release.
- Reset mid-message discards all buffered data and count. There is no partial output.
- `load_o`, `newtext_o` and `data_o` are registered. `data_o` = 0 whenever `load_o` = 0.
- SEND drives `load_o` = 1 for exactly 4 consecutive cycles, words 0,1,2,3. No stall once started.
- Latency:
  - Last byte accepted at edge t: PAD occupies t→t+1.
  - With the core ready and armed, the first `load_o` is high in the cycle after edge t+2.
  - A full non-last block skips PAD.
- PAD2 adds 1 cycle, then WAIT.
- While `core_ready_i` = 0 in WAIT: `load_o` = 0, `byte_ready_o` = 0, state held.
- Each wait with the core idle repeats the `armed` rule.

## Test plan
- **"a" (`0x61`, `last_i`):** 4 loads, `newtext_o` = 1 on the first only.
  - word 0 = `128'h00008061_00000000_00000000_00000000`;
  - words 1–2 = 0;
  - word 3 = `128'h00000000_00000000_00000008_00000000`.
- **"abc":** word 0 = `128'h80636261_00000000_00000000_00000000`; word 3 lane 2 = `0x00000018`.
- **56 bytes of `0x00`:** two blocks (8 loads). Only load 1 has `newtext_o`.
  - Block 1: word 3 = `128'h0..._00000080_00000000`.
  - Block 2: words 0–2 = 0; word 3 lane 2 = `0x000001C0`.
- **64 bytes of `0x00`:** block 1 all zero. Block 2 word 0 = `128'h00000080_0..._0`; word 3 lane 2 = `0x00000200`.
- **`core_ready_i` held 0 after "a" is accepted:** `load_o` and `byte_ready_o` stay 0 for 20 cycles. Raising `core_ready_i` gives 4 consecutive loads. With `core_ready_i` kept 1, no second launch occurs.
- **Reset asserted after 10 bytes:** all outputs 0 immediately. After release, "a" reproduces the first scenario exactly, including `newtext_o`.
